alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation is in flight at a time. MUL and DIV hold the ALU for MC_WAIT extra cycles.
module alu_arbiter #(
   parameter int MC_WAIT = 1
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,

   output logic [4:0]  alu_control,
   output logic [31:0] alu_data1,
   output logic [31:0] alu_data2,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [4:0] OP_MUL = 5'b01000;
   localparam logic [4:0] OP_DIV = 5'b01001;
   localparam logic [4:0] OP_NOP = 5'b10101;

   localparam logic [3:0] WAIT_LOAD = 4'(MC_WAIT);

   logic [1:0]  state;
   logic [4:0]  lat_op;
   logic [31:0] lat_a;
   logic [31:0] lat_b;
   logic        lat_id;
   logic        last_grant;
   logic [3:0]  wait_cnt;

   logic        grant_any;
   logic        grant_id;
   logic        lat_illegal;
   logic        lat_muldiv;
   logic        alu_drive;

   // Grant is a pure function of IDLE and the valids, so ready rises in the same cycle as valid.
   assign grant_any  = (state == IDLE) && !reset && (req0_valid || req1_valid);
   assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = grant_any && !grant_id;
   assign req1_ready = grant_any &&  grant_id;

   assign lat_illegal = (lat_op > OP_NOP);
   assign lat_muldiv  = (lat_op == OP_MUL) || (lat_op == OP_DIV);

   // Illegal opcodes never reach the ALU. It sees a NOP with zeroed operands instead.
   assign alu_drive   = ((state == EXEC) || (state == WAIT)) && !lat_illegal;
   assign alu_control = alu_drive ? lat_op : OP_NOP;
   assign alu_data1   = alu_drive ? lat_a  : 32'd0;
   assign alu_data2   = alu_drive ? lat_b  : 32'd0;

   assign rsp_valid = (state == RESP);

   // NOTE: all state here is registered with non-blocking assignments so every
   // branch reads the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         lat_op     <= OP_NOP;
         lat_a      <= 32'd0;
         lat_b      <= 32'd0;
         lat_id     <= 1'b0;
         last_grant <= 1'b1;
         wait_cnt   <= 4'd0;
         rsp_id     <= 1'b0;
         rsp_result <= 32'd0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  lat_op     <= grant_id ? req1_op : req0_op;
                  lat_a      <= grant_id ? req1_a  : req0_a;
                  lat_b      <= grant_id ? req1_b  : req0_b;
                  lat_id     <= grant_id;
                  last_grant <= grant_id;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (lat_illegal) begin
                  rsp_id     <= lat_id;
                  rsp_result <= 32'd0;
                  rsp_zero   <= 1'b0;
                  rsp_err    <= 1'b1;
                  state      <= RESP;
               end else if (lat_muldiv) begin
                  wait_cnt <= WAIT_LOAD;
                  state    <= WAIT;
               end else begin
                  rsp_id     <= lat_id;
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
                  rsp_err    <= 1'b0;
                  state      <= RESP;
               end
            end
            WAIT: begin
               // Counter is loaded with MC_WAIT, so the capture happens on the MC_WAIT-th WAIT cycle.
               if (wait_cnt <= 4'd1) begin
                  wait_cnt   <= 4'd0;
                  rsp_id     <= lat_id;
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
                  rsp_err    <= 1'b0;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a simple behavioural ALU model, MC_WAIT = 3.
module tb_alu_arbiter;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_MUL = 5'b01000;
   localparam logic [4:0] OP_DIV = 5'b01001;
   localparam logic [4:0] OP_NOP = 5'b10101;
   localparam logic [4:0] OP_BAD = 5'b11111;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_op, req1_op, alu_control;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [31:0] alu_data1, alu_data2, alu_result;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [31:0] rsp_result;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   alu_arbiter #(.MC_WAIT(3)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_control(alu_control), .alu_data1(alu_data1), .alu_data2(alu_data2),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   // Behavioural shared ALU; NOP returns a non-zero pattern so a wrongly captured NOP is visible.
   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      case (alu_control)
         OP_ADD:  alu_result = alu_data1 + alu_data2;
         OP_SUB:  alu_result = alu_data1 - alu_data2;
         OP_MUL:  alu_result = alu_data1 * alu_data2;
         OP_DIV:  alu_result = (alu_data2 != 0) ? alu_data1 / alu_data2 : 32'd0;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end
   assign alu_zero = (alu_result == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation from requester id at a negedge with rsp_ready=1 and check the response.
   task automatic do_op(input string tag, input logic id, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input int exp_drive, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err);
      int lat;
      int drive;
      @(negedge clock);
      rsp_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      #1;
      check({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, !id});
      check({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, id});
      @(negedge clock);
      // Changing the request after acceptance must not affect the operation.
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 32'h5555_5555; req1_a = 32'h5555_5555; req0_op = OP_SUB; req1_op = OP_SUB;
      lat = 1;
      drive = 0;
      while (!rsp_valid && lat < 40) begin
         if (alu_control != OP_NOP) drive++;
         @(negedge clock);
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_alu_cycles"}, drive, exp_drive);
      check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
      check({tag, "_result"}, rsp_result, exp_res);
      check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
   endtask

   initial begin
      int grants[$];
      int both;
      int seen;

      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 0; req0_b = 0;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 0; req1_b = 0;
      repeat (2) @(negedge clock);
      check("reset_ready0", {31'd0, req0_ready}, 32'd0);
      check("reset_ready1", {31'd0, req1_ready}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_result", rsp_result, 32'd0);
      check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("reset_alu_ctl", {27'd0, alu_control}, {27'd0, OP_NOP});
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;

      do_op("add", 1'b0, OP_ADD, 32'd5, 32'd7, 2, 1, 32'd12, 1'b0, 1'b0);
      do_op("div", 1'b1, OP_DIV, 32'd100, 32'd10, 5, 4, 32'd10, 1'b0, 1'b0);
      do_op("illegal", 1'b0, OP_BAD, 32'd9, 32'd9, 2, 0, 32'd0, 1'b0, 1'b1);
      do_op("mul", 1'b1, OP_MUL, 32'd7, 32'd6, 5, 4, 32'd42, 1'b0, 1'b0);

      // SUB with backpressure; requester 1 waits throughout.
      @(negedge clock);
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'd3; req0_b = 32'd3;
      #1 check("sub_ready0", {31'd0, req0_ready}, 32'd1);
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd1;
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sub_hold_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
         check($sformatf("sub_hold_result%0d", i), rsp_result, 32'd0);
         check($sformatf("sub_hold_zero%0d", i), {31'd0, rsp_zero}, 32'd1);
         check($sformatf("sub_hold_ready1_%0d", i), {31'd0, req1_ready}, 32'd0);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      #1 check("sub_release_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clock);
      #1 check("after_release_ready1", {31'd0, req1_ready}, 32'd1);
      @(negedge clock);
      req1_valid = 1'b0;
      repeat (3) @(negedge clock);

      // Both requesters held after reset: grants must alternate starting with 0.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1;  req0_b = 32'd2;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd10; req1_b = 32'd20;
      both = 0;
      for (int c = 0; c < 60 && grants.size() < 4; c++) begin
         #1;
         if (req0_ready && req1_ready) both++;
         if (req0_ready) grants.push_back(0);
         else if (req1_ready) grants.push_back(1);
         if (rsp_valid) check("rr_result", rsp_result, rsp_id ? 32'd30 : 32'd3);
         @(negedge clock);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr_count", grants.size(), 4);
      check("rr_both_ready", both, 0);
      for (int i = 0; i < grants.size(); i++)
         check($sformatf("rr_grant%0d", i), grants[i], i % 2);
      repeat (4) @(negedge clock);

      // Reset in the middle of a MUL's WAIT phase discards it.
      req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 32'd3; req0_b = 32'd4;
      @(negedge clock);
      req0_valid = 1'b0;
      @(negedge clock);
      check("rst_wait_alu_busy", {27'd0, alu_control}, {27'd0, OP_MUL});
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_wait_alu_nop", {27'd0, alu_control}, {27'd0, OP_NOP});
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) seen++;
         @(negedge clock);
      end
      check("rst_wait_no_rsp", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
